// File: rtl/lcd_scan_gen.sv
// ---------------------------------------------------------------------------
// lcd_scan_gen
// Raster timing generator for an LCD panel. Walks active area, porches and
// sync pulses line by line. Requests each active pixel from an upstream
// source one cycle ahead, then presents it with registered timing signals.
//
// Optional build macro: LCD_SCAN_TESTPAT_EN
//   defined   -> colour comes from an internal red/black checkerboard,
//                pix_r/g/b are ignored (px_req/nx/ny still driven)
//   undefined -> colour is the upstream pixel sampled with the request
//
// Ports
//   clk          in   pixel clock, rising edge
//   rst          in   asynchronous active-high reset
//   run          in   1 = scan continuously, 0 = stop at end of frame
//   px_req       out  upstream must answer for (nx,ny) (combinational)
//   nx, ny       out  column/row of requested pixel, 0 when no request
//   pix_r/g/b    in   upstream pixel, sampled at the edge after px_req
//   x, y         out  coordinate of current pixel, held while de=0
//   r, g, b      out  output colour, 0 outside the active area
//   de           out  (x,y) is in the active area
//   hsync/vsync  out  active-high sync pulses
//   frame_start  out  one-clock pulse with pixel (0,0)
//   busy         out  scanner not idle
// ---------------------------------------------------------------------------
module lcd_scan_gen #(
    parameter int unsigned H_ACTIVE = 480,
    parameter int unsigned V_ACTIVE = 272,
    parameter int unsigned H_FP     = 2,
    parameter int unsigned H_SYNC   = 41,
    parameter int unsigned H_BP     = 2,
    parameter int unsigned V_FP     = 2,
    parameter int unsigned V_SYNC   = 10,
    parameter int unsigned V_BP     = 2,
    parameter int unsigned TILE     = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    output logic       px_req,
    output logic [9:0] nx,
    output logic [9:0] ny,
    input  logic [7:0] pix_r,
    input  logic [7:0] pix_g,
    input  logic [7:0] pix_b,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       de,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       busy
);

    localparam int unsigned CW      = 10;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned VS_LO   = V_ACTIVE + V_FP;
    localparam int unsigned VS_HI   = VS_LO + V_SYNC;
    localparam int unsigned PERIOD  = 2 * TILE;

    // Geometry must fit the 10-bit counters; every phase must last >= 1.
    generate
        if (H_ACTIVE > 1023 || V_ACTIVE > 1023 || V_TOTAL > 1024) begin : g_bad_size
            $error("lcd_scan_gen: geometry exceeds 10-bit counters");
        end
        if (H_ACTIVE == 0 || V_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
            V_FP == 0 || V_SYNC == 0 || V_BP == 0 || TILE == 0) begin : g_bad_zero
            $error("lcd_scan_gen: zero-length timing phase or tile");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ACT   = 3'd1,
        S_HFP   = 3'd2,
        S_HSYNC = 3'd3,
        S_HBP   = 3'd4
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_hcnt;      // clocks elapsed in current line phase
    logic [CW-1:0]   r_line;      // line within frame

    state_t          w_state_nxt;
    logic [CW-1:0]   w_hcnt_nxt;
    logic [CW-1:0]   w_line_nxt;
    logic            w_de_nxt;
    logic            w_vs_nxt;
    logic [7:0]      w_r;
    logic [7:0]      w_g;
    logic [7:0]      w_b;

    // Next position of the raster walk; outputs are registered from it.
    always_comb begin
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt + CW'(1);
        w_line_nxt  = r_line;
        case (r_state)
            S_IDLE: begin
                w_hcnt_nxt = '0;
                w_line_nxt = '0;
                if (run) w_state_nxt = S_ACT;
            end
            S_ACT: begin
                if (r_hcnt == CW'(H_ACTIVE - 1)) begin
                    w_state_nxt = S_HFP;
                    w_hcnt_nxt  = '0;
                end
            end
            S_HFP: begin
                if (r_hcnt == CW'(H_FP - 1)) begin
                    w_state_nxt = S_HSYNC;
                    w_hcnt_nxt  = '0;
                end
            end
            S_HSYNC: begin
                if (r_hcnt == CW'(H_SYNC - 1)) begin
                    w_state_nxt = S_HBP;
                    w_hcnt_nxt  = '0;
                end
            end
            S_HBP: begin
                if (r_hcnt == CW'(H_BP - 1)) begin
                    w_hcnt_nxt = '0;
                    // run is only consulted at the frame boundary
                    if (r_line == CW'(V_TOTAL - 1)) begin
                        w_line_nxt  = '0;
                        w_state_nxt = run ? S_ACT : S_IDLE;
                    end else begin
                        w_line_nxt  = r_line + CW'(1);
                        w_state_nxt = S_ACT;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_hcnt_nxt  = '0;
                w_line_nxt  = '0;
            end
        endcase
    end

    assign w_de_nxt = (w_state_nxt == S_ACT) && (w_line_nxt < CW'(V_ACTIVE));
    assign w_vs_nxt = (w_line_nxt >= CW'(VS_LO)) && (w_line_nxt < CW'(VS_HI));

    // Request for the pixel that de will show after the next edge.
    assign px_req = w_de_nxt & ~rst;
    assign nx     = px_req ? w_hcnt_nxt : '0;
    assign ny     = px_req ? w_line_nxt : '0;

`ifdef LCD_SCAN_TESTPAT_EN
    logic w_par;
    logic w_unused_pix;

    assign w_par = ((32'(w_hcnt_nxt) % PERIOD) >= TILE) ^ ((32'(w_line_nxt) % PERIOD) >= TILE);
    assign w_r   = w_par ? 8'd0 : 8'd150;
    assign w_g   = 8'd0;
    assign w_b   = 8'd0;
    assign w_unused_pix = ^{pix_r, pix_g, pix_b};
`else
    assign w_r = pix_r;
    assign w_g = pix_g;
    assign w_b = pix_b;
`endif

    // State, counters and all panel-facing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hcnt      <= '0;
            r_line      <= '0;
            x           <= '0;
            y           <= '0;
            r           <= '0;
            g           <= '0;
            b           <= '0;
            de          <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hcnt      <= w_hcnt_nxt;
            r_line      <= w_line_nxt;
            de          <= w_de_nxt;
            hsync       <= (w_state_nxt == S_HSYNC);
            vsync       <= w_vs_nxt;
            busy        <= (w_state_nxt != S_IDLE);
            frame_start <= w_de_nxt && (w_hcnt_nxt == '0) && (w_line_nxt == '0);
            if (w_de_nxt) begin
                x <= w_hcnt_nxt;
                y <= w_line_nxt;
                r <= w_r;
                g <= w_g;
                b <= w_b;
            end else begin
                r <= '0;
                g <= '0;
                b <= '0;
            end
        end
    end

endmodule
